// File: rtl/finish_line_detector_if.sv
// Frame-rate handshake between the object-state controllers and the finish-line detector.
// The master side supplies frame pulses and descriptors; the slave side returns race status.
interface finish_line_detector_if #(
  parameter int TIME_W = 16
);
  logic              frame_start;
  logic              race_start;
  logic [0:4][0:10]  fl_state;
  logic [0:4][0:10]  car_state;
  logic              race_active;
  logic              line_touch;
  logic              race_finished;
  logic [TIME_W-1:0] finish_time;
  logic              game_over;

  modport master (
    output frame_start, race_start, fl_state, car_state,
    input  race_active, line_touch, race_finished, finish_time, game_over
  );

  modport slave (
    input  frame_start, race_start, fl_state, car_state,
    output race_active, line_touch, race_finished, finish_time, game_over
  );
endinterface

// File: rtl/finish_line_detector.sv
// Detects the player car crossing the finish line, latches the race time in frames
// and pulses game_over after a post-finish hold period.
module finish_line_detector #(
  parameter int FL_IMG_ID   = 10,
  parameter int HOLD_FRAMES = 120,
  parameter int TIME_W      = 16
) (
  input logic                    clk,
  input logic                    resetN,
  finish_line_detector_if.slave  bus
);

  localparam int HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    WAIT_ABOVE = 3'd0,
    ARMED      = 3'd1,
    CROSSING   = 3'd2,
    FINISHED   = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [TIME_W-1:0]   timer, timer_nx, timer_inc;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic [TIME_W-1:0]   finish_time_q, finish_time_nx;
  logic                finished_q, finished_nx;
  logic                touch_q, touch_nx;
  logic                game_over_q, game_over_nx;

  // Descriptor fields: [0]=img_id, [1]=x, [2]=y, [3]=w, [4]=h. y grows downward.
  logic [11:0] fl_y, fl_bot, car_y, car_bot;
  logic        fl_valid, above, overlap, past;

  assign fl_y     = {1'b0, bus.fl_state[2]};
  assign fl_bot   = fl_y + {1'b0, bus.fl_state[4]};
  assign car_y    = {1'b0, bus.car_state[2]};
  assign car_bot  = car_y + {1'b0, bus.car_state[4]};
  assign fl_valid = (bus.fl_state[0] == 11'(FL_IMG_ID));

  assign above   = fl_valid && (fl_bot <= car_y);
  assign overlap = fl_valid && (fl_bot > car_y) && (fl_y < car_bot);
  assign past    = fl_valid && (fl_y >= car_bot);

  assign timer_inc = (timer == {TIME_W{1'b1}}) ? timer : timer + TIME_W'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    hold_nx        = hold_cnt;
    finish_time_nx = finish_time_q;
    finished_nx    = finished_q;
    touch_nx       = touch_q;
    game_over_nx   = 1'b0;

    if (bus.race_start) begin
      state_nx       = WAIT_ABOVE;
      timer_nx       = '0;
      hold_nx        = '0;
      finish_time_nx = '0;
      finished_nx    = 1'b0;
      touch_nx       = 1'b0;
    end else if (bus.frame_start) begin
      if (state != DONE) touch_nx = overlap;

      case (state)
        // The parked line sits below the screen, so past must not count before arming.
        WAIT_ABOVE: if (above) state_nx = ARMED;
        ARMED, CROSSING: begin
          timer_nx = timer_inc;
          if (past) begin
            state_nx       = FINISHED;
            finish_time_nx = timer_inc;
            finished_nx    = 1'b1;
            hold_nx        = '0;
          end else if (state == ARMED && overlap) begin
            state_nx = CROSSING;
          end else if (state == CROSSING && above) begin
            state_nx = ARMED;
          end
        end
        FINISHED: begin
          if (int'(hold_cnt) + 1 >= HOLD_FRAMES) begin
            state_nx     = DONE;
            game_over_nx = 1'b1;
          end else begin
            hold_nx = hold_cnt + HOLD_W'(1);
          end
        end
        DONE:    ;
        default: state_nx = WAIT_ABOVE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the asynchronous reset clears all control state at once, independent of the clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= WAIT_ABOVE;
      timer         <= '0;
      hold_cnt      <= '0;
      finish_time_q <= '0;
      finished_q    <= 1'b0;
      touch_q       <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      hold_cnt      <= hold_nx;
      finish_time_q <= finish_time_nx;
      finished_q    <= finished_nx;
      touch_q       <= touch_nx;
      game_over_q   <= game_over_nx;
    end
  end

  assign bus.race_active   = (state == ARMED) || (state == CROSSING);
  assign bus.line_touch    = touch_q;
  assign bus.race_finished = finished_q;
  assign bus.finish_time   = finish_time_q;
  assign bus.game_over     = game_over_q;

endmodule

// File: doc/finish_line_detector.md
Name: finish_line_detector

Overview:
- Consumes the per-frame finish-line object state (img_id, x, y, width, height) and the player-car object state, both packed 5x11-bit descriptors.
- Decides when the car has crossed the finish line and raises race-finished status.
- Latches the race time in frames and runs a post-finish hold countdown before signalling game end to the top-level game FSM.
- Sits between the object-state controllers and the game-control / score logic.

Parameters:
FL_IMG_ID, 10, img_id value a valid finish-line descriptor must carry; any other id is treated as "no line".
HOLD_FRAMES, 120, frames to hold in FINISHED before pulsing game_over.
TIME_W, 16, width of the frame timer and finish_time.

Ports:
clk  in  1  system clock
resetN  in  1  async active-low reset
frame_start  in  1  one-clk pulse per video frame
race_start  in  1  one-clk pulse; restarts detection and timer
fl_state  in  [0:4][0:10]  finish-line descriptor {img_id,x,y,w,h}
car_state  in  [0:4][0:10]  player-car descriptor, same layout
race_active  out  1  high while timer runs (ARMED/CROSSING)
line_touch  out  1  high while line and car overlap vertically
race_finished  out  1  high from crossing until reset/race_start
finish_time  out  TIME_W  frames from race_start to crossing; 0 until finished
game_over  out  1  one-clk pulse HOLD_FRAMES frames after finish

Behaviour:
- Reset (resetN low, asynchronous):
  - state=WAIT_ABOVE; timer=0, hold_cnt=0.
  - All outputs 0.
- Evaluation happens only in cycles with frame_start=1, using fl_state/car_state sampled that cycle. Outputs are registered and valid the next clk.
- Geometry uses unsigned 12-bit sums; y grows downward.
  - fl_bot = fl.y + fl.h; car_bot = car.y + car.h.
  - above = fl_bot <= car.y
  - overlap = fl_bot > car.y && fl.y < car_bot
  - past = fl.y >= car_bot
  - valid = fl.img_id == FL_IMG_ID; if !valid, above/overlap/past are all 0.
- FSM, transitions on frame_start only:
  - WAIT_ABOVE: above -> ARMED. past is ignored here, because the line's parked default position lies below the screen and must not count as a crossing.
  - ARMED: timer += 1.
    - overlap -> CROSSING.
    - past (line jumped over the car in one frame) -> FINISHED.
  - CROSSING: timer += 1.
    - past -> FINISHED.
    - above (line retreated) -> ARMED.
  - FINISHED: timer frozen; hold_cnt += 1 until HOLD_FRAMES, then DONE.
  - DONE: terminal; pulses game_over and stays until race_start or reset.
- Entering FINISHED:
  - finish_time <= timer + 1, which includes the crossing frame.
  - race_finished <= 1; hold_cnt <= 0.
- game_over: asserted exactly one clk, on the FINISHED->DONE transition.
- race_active = 1 in ARMED or CROSSING.
- line_touch = registered overlap, updated every frame_start in every state except DONE.
- timer saturates at all-ones and does not wrap; finish_time is the saturated value if reached.
- race_start has priority over frame_start in the same clk. It forces WAIT_ABOVE, clears timer, hold_cnt, finish_time, race_finished, line_touch and game_over, and skips that frame's evaluation.
- Reset mid-race returns everything to reset values immediately.
- No evaluation occurs without frame_start; input changes between pulses are ignored.

Test Plan:
- Reset, then frame_start with fl={10,166,780,248,64}, car={1,280,380,32,64} -> stays WAIT_ABOVE, race_finished=0, finish_time=0 (parked line ignored).
- race_start; frame with fl.y=100 (fl_bot=164 ≤ 380) -> ARMED, race_active=1. Next 5 frames fl.y=200 -> timer=5, line_touch=0.
- Continue: fl.y=340 (overlap) -> CROSSING, line_touch=1. Then fl.y=444 (=car_bot) -> FINISHED, race_finished=1, finish_time=7, race_active=0.
- After FINISHED, HOLD_FRAMES=3 override: exactly one game_over pulse on the 3rd subsequent frame_start; none before or after.
- ARMED, fl.y jumps 100->500 in one frame -> FINISHED directly. fl.img_id=5 with overlapping geometry -> no state change.
- race_start and frame_start in the same clk while in CROSSING -> WAIT_ABOVE, timer=0, all outputs 0. Asserting resetN low mid-CROSSING clears outputs without waiting for a clk edge.
